// File: rtl/expand_quality_scores.sv
// expand_quality_scores
// Streaming decompressor for binned base-quality reads. A packed read of 2-bit
// bin codes is accepted in one cycle. It is then replayed as BEAT quality bytes
// per beat. Each code selects one of four representative bytes, which are
// captured together with the read.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   qualityValue0..3   representative byte for codes 2'b00..2'b11
//   inValid/inReady    read handshake
//   inQuality          packed codes, symbol i at [2i+1:2i]
//   inLength           number of valid symbols (clamped to LENGTH)
//   outValid/outReady  beat handshake
//   outData            BEAT bytes, byte j = symbol beat*BEAT+j
//   outMask            per-byte valid flag
//   outLast            final beat of the current read
module expand_quality_scores #(
    parameter int LENGTH = 64,
    parameter int BEAT   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  qualityValue0,
    input  logic [7:0]                  qualityValue1,
    input  logic [7:0]                  qualityValue2,
    input  logic [7:0]                  qualityValue3,
    input  logic                        inValid,
    output logic                        inReady,
    input  logic [LENGTH*2-1:0]         inQuality,
    input  logic [$clog2(LENGTH+1)-1:0] inLength,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [BEAT*8-1:0]           outData,
    output logic [BEAT-1:0]             outMask,
    output logic                        outLast
);

    localparam int NBEATS = LENGTH / BEAT;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LW     = $clog2(LENGTH + 1);

    typedef enum logic {
        IDLE,
        EMIT
    } stateT;

    stateT                 stateQ, stateD;
    logic [LENGTH*2-1:0]   codesQ, codesD;
    logic [3:0][7:0]       valsQ, valsD;
    logic [LW-1:0]         lenQ, lenD;
    logic [BW-1:0]         beatQ, beatD;
    logic [BW-1:0]         lastBeatQ, lastBeatD;

    logic [LW-1:0]         lenClamp;
    logic [BW-1:0]         lastBeatIn;
    logic [LW-1:0]         symIdx;
    logic [1:0]            code;
    logic                  accept;

    // The final beat index is worked out once at acceptance. outLast is then
    // a simple compare against the beat counter.
    always_comb begin
        lenClamp   = (inLength > LW'(LENGTH)) ? LW'(LENGTH) : inLength;
        lastBeatIn = '0;
        if (lenClamp != '0) begin
            lastBeatIn = BW'((lenClamp - LW'(1)) / LW'(BEAT));
        end
    end

    // Beat assembly: the registered codes, values and length feed only the
    // code-to-byte mux. Bytes past the read length are zeroed and unmasked.
    always_comb begin
        outValid = (stateQ == EMIT);
        outLast  = outValid && (beatQ == lastBeatQ);
        outData  = '0;
        outMask  = '0;
        symIdx   = '0;
        code     = '0;
        if (outValid) begin
            for (int j = 0; j < BEAT; j++) begin
                symIdx = LW'(beatQ) * LW'(BEAT) + LW'(j);
                if (symIdx < lenQ) begin
                    code              = codesQ[{symIdx, 1'b0} +: 2];
                    outData[8*j +: 8] = valsQ[code];
                    outMask[j]        = 1'b1;
                end
            end
        end
    end

    // A new read can also be taken on the last-beat handshake. This keeps
    // back-to-back reads free of idle cycles.
    always_comb begin
        inReady   = (stateQ == IDLE) || (outValid && outReady && outLast);
        accept    = inValid && inReady;
        stateD    = stateQ;
        codesD    = codesQ;
        valsD     = valsQ;
        lenD      = lenQ;
        beatD     = beatQ;
        lastBeatD = lastBeatQ;
        case (stateQ)
            IDLE: begin
                if (accept) begin
                    stateD = (lenClamp == '0) ? IDLE : EMIT;
                end
            end
            EMIT: begin
                if (outReady) begin
                    if (!outLast) begin
                        beatD = beatQ + BW'(1);
                    end else if (inValid) begin
                        stateD = (lenClamp == '0) ? IDLE : EMIT;
                    end else begin
                        stateD = IDLE;
                    end
                end
            end
            default: stateD = IDLE;
        endcase
        if (accept) begin
            codesD    = inQuality;
            valsD     = {qualityValue3, qualityValue2, qualityValue1, qualityValue0};
            lenD      = lenClamp;
            beatD     = '0;
            lastBeatD = lastBeatIn;
        end
    end

    // Reset takes priority over any read offered in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= IDLE;
            codesQ    <= '0;
            valsQ     <= '0;
            lenQ      <= '0;
            beatQ     <= '0;
            lastBeatQ <= '0;
        end else begin
            stateQ    <= stateD;
            codesQ    <= codesD;
            valsQ     <= valsD;
            lenQ      <= lenD;
            beatQ     <= beatD;
            lastBeatQ <= lastBeatD;
        end
    end

endmodule

// File: tb/tb_expand_quality_scores.sv
module tb_expand_quality_scores;

    logic         clk;
    logic         rst;
    logic [7:0]   qualityValue0, qualityValue1, qualityValue2, qualityValue3;
    logic         inValid;
    logic         inReady;
    logic [127:0] inQuality;
    logic [6:0]   inLength;
    logic         outValid;
    logic         outReady;
    logic [63:0]  outData;
    logic [7:0]   outMask;
    logic         outLast;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  mask;
        logic        last;
    } beatT;

    beatT sb[$];
    int   checks = 0;
    int   errors = 0;

    logic  stallPending = 1'b0;
    beatT  held;

    expand_quality_scores #(.LENGTH(64), .BEAT(8)) dut (
        .clk(clk),
        .rst(rst),
        .qualityValue0(qualityValue0),
        .qualityValue1(qualityValue1),
        .qualityValue2(qualityValue2),
        .qualityValue3(qualityValue3),
        .inValid(inValid),
        .inReady(inReady),
        .inQuality(inQuality),
        .inLength(inLength),
        .outValid(outValid),
        .outReady(outReady),
        .outData(outData),
        .outMask(outMask),
        .outLast(outLast)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung handshake
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every beat handshake and also verifies
    // that a stalled beat is held unchanged into the next cycle.
    always @(negedge clk) begin
        beatT exp;
        if (rst) begin
            stallPending = 1'b0;
        end else begin
            if (stallPending && outValid) begin
                checkOutput("stall_hold", {outData, outMask, outLast}, {held.data, held.mask, held.last});
            end
            stallPending = 1'b0;
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("beat_data", outData, exp.data);
                    checkOutput("beat_mask", {56'd0, outMask}, {56'd0, exp.mask});
                    checkOutput("beat_last", {63'd0, outLast}, {63'd0, exp.last});
                end
            end else if (outValid) begin
                stallPending = 1'b1;
                held = '{data: outData, mask: outMask, last: outLast};
            end
        end
    end

    function automatic beatT mkBeat(input logic [63:0] d, input logic [7:0] m, input logic l);
        beatT b;
        b.data = d;
        b.mask = m;
        b.last = l;
        return b;
    endfunction

    // Reference decode of a whole read into expected beats
    task automatic pushModel(input logic [127:0] codes, input logic [3:0][7:0] vals, input int len);
        int nb;
        beatT b;
        logic [1:0] c;
        nb = (len + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int j = 0; j < 8; j++) begin
                if (bi * 8 + j < len) begin
                    c = codes[2 * (bi * 8 + j) +: 2];
                    b.data[8 * j +: 8] = vals[c];
                    b.mask[j] = 1'b1;
                end
            end
            b.last = (bi == nb - 1);
            sb.push_back(b);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] codes, input logic [3:0][7:0] vals, input logic [6:0] len);
        int n;
        qualityValue0 = vals[0];
        qualityValue1 = vals[1];
        qualityValue2 = vals[2];
        qualityValue3 = vals[3];
        inQuality = codes;
        inLength  = len;
        inValid   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inReady && n < 500);
        if (!inReady) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitDrain(input bit randomReady);
        int n;
        n = 0;
        while ((sb.size() != 0 || outValid) && n < 3000) begin
            @(posedge clk);
            #1;
            if (randomReady) outReady = 1'($urandom_range(0, 1));
            n++;
        end
        checkOutput("drain_in_time", {63'd0, n >= 3000}, 64'd0);
        outReady = 1'b1;
    endtask

    initial begin
        logic [127:0]    codes;
        logic [3:0][7:0] vals;

        rst = 1'b1;
        inValid = 1'b0;
        inQuality = '0;
        inLength = '0;
        outReady = 1'b1;
        qualityValue0 = 8'd0;
        qualityValue1 = 8'd0;
        qualityValue2 = 8'd0;
        qualityValue3 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_outValid", {63'd0, outValid}, 64'd0);
        checkOutput("reset_inReady", {63'd0, inReady}, 64'd1);
        checkOutput("reset_outData", outData, 64'd0);
        checkOutput("reset_outMask", {56'd0, outMask}, 64'd0);
        checkOutput("reset_outLast", {63'd0, outLast}, 64'd0);

        // Basic decode: codes cycle 0,1,2,3
        $display("[TB] basic decode");
        for (int i = 0; i < 64; i++) codes[2 * i +: 2] = 2'(i % 4);
        vals = {8'd40, 8'd30, 8'd15, 8'd2};
        for (int b = 0; b < 8; b++) sb.push_back(mkBeat(64'h281E0F02_281E0F02, 8'hFF, b == 7));
        @(posedge clk);
        #1;
        applyStimulus(codes, vals, 7'd64);
        waitDrain(1'b0);

        // Partial read of 13 symbols, all code 3
        $display("[TB] partial read");
        codes = {128{1'b1}};
        vals = {8'h29, 8'h00, 8'h00, 8'h00};
        sb.push_back(mkBeat(64'h29292929_29292929, 8'hFF, 1'b0));
        sb.push_back(mkBeat(64'h00000029_29292929, 8'h1F, 1'b1));
        applyStimulus(codes, vals, 7'd13);
        waitDrain(1'b0);

        // Zero length read is dropped
        $display("[TB] zero length");
        applyStimulus(codes, vals, 7'd0);
        @(negedge clk);
        checkOutput("zero_len_outValid", {63'd0, outValid}, 64'd0);
        checkOutput("zero_len_inReady", {63'd0, inReady}, 64'd1);

        // Length above LENGTH is clamped
        $display("[TB] clamp");
        codes = {$urandom, $urandom, $urandom, $urandom};
        vals = {8'd37, 8'd25, 8'd11, 8'd6};
        pushModel(codes, vals, 64);
        @(posedge clk);
        #1;
        applyStimulus(codes, vals, 7'd65);
        waitDrain(1'b0);

        // Back-pressure with value change mid-read
        $display("[TB] back-pressure");
        codes = {$urandom, $urandom, $urandom, $urandom};
        vals = {8'd50, 8'd33, 8'd20, 8'd3};
        pushModel(codes, vals, 64);
        outReady = 1'b0;
        applyStimulus(codes, vals, 7'd64);
        qualityValue0 = 8'hAA;
        qualityValue1 = 8'hBB;
        qualityValue2 = 8'hCC;
        qualityValue3 = 8'hDD;
        waitDrain(1'b1);

        // Back-to-back reads with inValid held
        $display("[TB] back-to-back");
        vals = {8'h33, 8'h22, 8'h11, 8'h01};
        sb.push_back(mkBeat(64'h11111111_11111111, 8'hFF, 1'b0));
        sb.push_back(mkBeat(64'h11111111_11111111, 8'hFF, 1'b1));
        sb.push_back(mkBeat(64'h22222222_22222222, 8'hFF, 1'b0));
        sb.push_back(mkBeat(64'h22222222_22222222, 8'hFF, 1'b1));
        @(posedge clk);
        #1;
        qualityValue0 = vals[0];
        qualityValue1 = vals[1];
        qualityValue2 = vals[2];
        qualityValue3 = vals[3];
        inQuality = {64{2'b01}};
        inLength = 7'd16;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inQuality = {64{2'b10}};
        @(negedge clk);
        checkOutput("b2b_first_beat_ready", {62'd0, outValid, inReady}, {62'd0, 2'b10});
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("b2b_last_accept", {62'd0, outLast, inReady}, {62'd0, 2'b11});
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_no_bubble", {63'd0, outValid}, 64'd1);
        waitDrain(1'b0);

        // Reset during beat 3 of 8
        $display("[TB] reset mid-read");
        codes = {$urandom, $urandom, $urandom, $urandom};
        vals = {8'd9, 8'd8, 8'd7, 8'd6};
        pushModel(codes, vals, 64);
        applyStimulus(codes, vals, 7'd64);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        inValid = 1'b1;
        inLength = 7'd8;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inValid = 1'b0;
        sb.delete();
        checkOutput("rst_mid_outValid", {63'd0, outValid}, 64'd0);
        checkOutput("rst_mid_inReady", {63'd0, inReady}, 64'd1);
        checkOutput("rst_mid_outLast", {63'd0, outLast}, 64'd0);
        @(negedge clk);
        checkOutput("rst_same_cycle_not_accepted", {63'd0, outValid}, 64'd0);
        codes = {$urandom, $urandom, $urandom, $urandom};
        vals = {8'd70, 8'd60, 8'd50, 8'd40};
        pushModel(codes, vals, 16);
        @(posedge clk);
        #1;
        applyStimulus(codes, vals, 7'd16);
        waitDrain(1'b0);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
